// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash sequencer: state encoding, phase ids
// and the rinse-count clamp.
package wash_pkg;

    typedef enum logic [2:0] {
        StIdle   = 3'd0,
        StWash   = 3'd1,
        StRinse  = 3'd2,
        StSpin   = 3'd3,
        StDone   = 3'd4,
        StPaused = 3'd5,
        StFault  = 3'd6
    } wash_state_e;

    // Phase ids remembered across a pause; PhaseDone covers a pause that
    // lands on the final SPIN cycle.
    localparam logic [1:0] PhaseWash  = 2'd0;
    localparam logic [1:0] PhaseRinse = 2'd1;
    localparam logic [1:0] PhaseSpin  = 2'd2;
    localparam logic [1:0] PhaseDone  = 2'd3;

    function automatic wash_state_e phase_state(input logic [1:0] phase);
        case (phase)
            PhaseWash:  return StWash;
            PhaseRinse: return StRinse;
            PhaseSpin:  return StSpin;
            default:    return StDone;
        endcase
    endfunction

    // 0 means "at least one pass"; requests above the maximum are clamped.
    function automatic int unsigned clamp_rinses(input int unsigned req,
                                                 input int unsigned max_rinses);
        if (req == 0) begin
            return 1;
        end else if (req > max_rinses) begin
            return max_rinses;
        end else begin
            return req;
        end
    endfunction

endpackage

// File: rtl/phase_timer.sv
// Loadable down-counter that times one wash phase; done flags a zero count.
module phase_timer #(
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load_i,
    input  logic [CNT_W-1:0] load_val_i,
    input  logic             hold_i,
    output logic             done_o
);

    logic [CNT_W-1:0] count_q, count_d;

    // Load wins over counting; the count never wraps below zero.
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = load_val_i;
        end else if (!hold_i && count_q != '0) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    // Count register with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/wash_sequencer.sv
// Washer cycle sequencer: WASH -> N x RINSE -> SPIN -> DONE with pause,
// abort and sensor-loss fault handling. Outputs are Moore decodes.
module wash_sequencer
    import wash_pkg::*;
#(
    parameter int unsigned CNT_W        = 16,
    parameter int unsigned WASH_CYCLES  = 100,
    parameter int unsigned RINSE_CYCLES = 60,
    parameter int unsigned SPIN_CYCLES  = 40,
    parameter int unsigned MAX_RINSES   = 3,
    parameter int unsigned RC_W         = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            start,
    input  logic            pause,
    input  logic            abort,
    input  logic            water_ready,
    input  logic            temp_ready,
    input  logic            load_ready,
    input  logic [RC_W-1:0] rinse_count,
    output logic            wash_enable,
    output logic            rinse_enable,
    output logic            spin_enable,
    output logic            complete,
    output logic            fault,
    output logic            busy,
    output logic [2:0]      state
);

    localparam int unsigned TGT_W = (MAX_RINSES < 2) ? 1 : $clog2(MAX_RINSES + 1);

    localparam logic [CNT_W-1:0] WashLoad  = CNT_W'(WASH_CYCLES - 1);
    localparam logic [CNT_W-1:0] RinseLoad = CNT_W'(RINSE_CYCLES - 1);
    localparam logic [CNT_W-1:0] SpinLoad  = CNT_W'(SPIN_CYCLES - 1);

    localparam longint CntLimit = longint'(1) << CNT_W;

    if (WASH_CYCLES == 0 || RINSE_CYCLES == 0 || SPIN_CYCLES == 0 ||
        longint'(WASH_CYCLES) >= CntLimit || longint'(RINSE_CYCLES) >= CntLimit ||
        longint'(SPIN_CYCLES) >= CntLimit || MAX_RINSES == 0) begin : g_bad_cfg
        $error("wash_sequencer: phase durations must be in 1..2^CNT_W-1, MAX_RINSES >= 1");
    end

    wash_state_e      state_q, state_d;
    logic [1:0]       ret_q, ret_d;
    logic [TGT_W-1:0] target_q, target_d;
    logic [TGT_W-1:0] rinse_done_q, rinse_done_d;
    logic [1:0]       adv_phase;
    logic             tmr_load, tmr_hold, tmr_done;
    logic [CNT_W-1:0] tmr_val;
    logic             ready_all;

    assign ready_all = water_ready & temp_ready & load_ready;

    phase_timer #(
        .CNT_W (CNT_W)
    ) u_phase_timer (
        .clk        (clk),
        .reset      (reset),
        .load_i     (tmr_load),
        .load_val_i (tmr_val),
        .hold_i     (tmr_hold),
        .done_o     (tmr_done)
    );

    // Next-state, timer control and rinse bookkeeping.
    always_comb begin
        state_d      = state_q;
        ret_d        = ret_q;
        target_d     = target_q;
        rinse_done_d = rinse_done_q;
        adv_phase    = PhaseWash;
        tmr_load     = 1'b0;
        tmr_val      = '0;
        tmr_hold     = 1'b1;
        case (state_q)
            StIdle: begin
                if (start && ready_all) begin
                    state_d      = StWash;
                    tmr_load     = 1'b1;
                    tmr_val      = WashLoad;
                    target_d     = TGT_W'(clamp_rinses(32'(rinse_count), MAX_RINSES));
                    rinse_done_d = '0;
                end
            end
            StWash, StRinse, StSpin: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (state_q != StSpin && !water_ready) begin
                    state_d = StFault;
                end else begin
                    // This cycle counts toward the phase even if a pause follows;
                    // the phase advance it triggers is what a pause resumes into.
                    tmr_hold = 1'b0;
                    case (state_q)
                        StWash:  adv_phase = PhaseWash;
                        StRinse: adv_phase = PhaseRinse;
                        default: adv_phase = PhaseSpin;
                    endcase
                    if (tmr_done) begin
                        case (state_q)
                            StWash: begin
                                adv_phase = PhaseRinse;
                                tmr_load  = 1'b1;
                                tmr_val   = RinseLoad;
                            end
                            StRinse: begin
                                tmr_load = 1'b1;
                                if (({1'b0, rinse_done_q} + (TGT_W+1)'(1)) < {1'b0, target_q}) begin
                                    adv_phase    = PhaseRinse;
                                    tmr_val      = RinseLoad;
                                    rinse_done_d = rinse_done_q + TGT_W'(1);
                                end else begin
                                    adv_phase = PhaseSpin;
                                    tmr_val   = SpinLoad;
                                end
                            end
                            default: adv_phase = PhaseDone;
                        endcase
                    end
                    if (pause) begin
                        state_d = StPaused;
                        ret_d   = adv_phase;
                    end else begin
                        state_d = phase_state(adv_phase);
                    end
                end
            end
            StPaused: begin
                if (abort) begin
                    state_d = StIdle;
                end else if (!pause) begin
                    state_d = phase_state(ret_q);
                end
            end
            StDone:  state_d = StIdle;
            StFault: begin
                if (abort) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and bookkeeping registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= StIdle;
            ret_q        <= PhaseWash;
            target_q     <= '0;
            rinse_done_q <= '0;
        end else begin
            state_q      <= state_d;
            ret_q        <= ret_d;
            target_q     <= target_d;
            rinse_done_q <= rinse_done_d;
        end
    end

    assign wash_enable  = (state_q == StWash);
    assign rinse_enable = (state_q == StRinse);
    assign spin_enable  = (state_q == StSpin);
    assign complete     = (state_q == StDone);
    assign fault        = (state_q == StFault);
    assign busy         = (state_q != StIdle);
    assign state        = state_q;

endmodule
